// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages: WB control bit positions,
// MEM-stage FSM encoding and datapath width.
package mips_pkg;

  localparam int unsigned DATA_W = 32;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/branch_resolve.sv
// Combinational PC redirect decision from the EX branch flags.
module branch_resolve
  import mips_pkg::*;
(
  input  logic              is_jump,
  input  logic              branch_eq,
  input  logic              branch_inc,
  input  logic              zero,
  input  logic [DATA_W-1:0] jump_address,
  input  logic              in_wait,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target
);

  // The instruction sitting in EX/MEM during a memory wait is not a branch
  // that may redirect yet, so the redirect is suppressed.
  always_comb begin
    pc_src    = ~in_wait & (is_jump | (branch_eq & zero) | (branch_inc & ~zero));
    pc_target = jump_address;
  end

endmodule

// File: rtl/stage_mem.sv
// MIPS MEM stage: PC redirect, req/ack data-memory access with stall and
// timeout, and the MEM/WB pipeline register.
module stage_mem
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] data_b_in,
  input  logic [4:0]        regaddr_in,
  input  logic [1:0]        wbi_in,
  input  logic              M_in,
  input  logic              is_jump_in,
  input  logic              branch_eq_in,
  input  logic              branch_inc_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] jump_address_in,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        wb_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [4:0]        regaddr_o,
  output logic              err_o
);

  mem_state_e        state_q, state_d;
  logic [7:0]        cnt_q;
  logic [1:0]        hold_wb_q;
  logic [DATA_W-1:0] hold_alu_q;
  logic [4:0]        hold_reg_q;
  logic              access, misaligned, timeout;

  assign access     = M_in | wbi_in[WB_MEMTOREG];
  assign misaligned = access & (alu_in[1:0] != 2'b00);
  assign timeout    = (state_q == MEM_WAIT) && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign flush      = pc_src;

  branch_resolve u_branch_resolve (
    .is_jump      (is_jump_in),
    .branch_eq    (branch_eq_in),
    .branch_inc   (branch_inc_in),
    .zero         (zero_in),
    .jump_address (jump_address_in),
    .in_wait      (state_q == MEM_WAIT),
    .pc_src       (pc_src),
    .pc_target    (pc_target)
  );

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (access && !misaligned) begin
          stall   = 1'b1;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        // Release in the ack/timeout cycle so EX advances on the same edge.
        stall = ~mem_ack & ~timeout;
        if (mem_ack || timeout) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= MEM_IDLE;
      cnt_q      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wb_o       <= '0;
      err_o      <= 1'b0;
      mem_data_o <= '0;
      alu_o      <= '0;
      regaddr_o  <= '0;
      hold_wb_q  <= '0;
      hold_alu_q <= '0;
      hold_reg_q <= '0;
    end else begin
      state_q <= state_d;
      err_o   <= 1'b0;
      unique case (state_q)
        MEM_IDLE: begin
          if (!access) begin
            wb_o      <= wbi_in;
            alu_o     <= alu_in;
            regaddr_o <= regaddr_in;
          end else if (misaligned) begin
            wb_o  <= '0;
            err_o <= 1'b1;
          end else begin
            mem_req    <= 1'b1;
            mem_we     <= M_in;
            mem_addr   <= {alu_in[DATA_W-1:2], 2'b00};
            mem_wdata  <= data_b_in;
            hold_wb_q  <= wbi_in;
            hold_alu_q <= alu_in;
            hold_reg_q <= regaddr_in;
            cnt_q      <= '0;
            wb_o       <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            wb_o      <= hold_wb_q;
            alu_o     <= hold_alu_q;
            regaddr_o <= hold_reg_q;
            if (hold_wb_q[WB_MEMTOREG] && !mem_we) mem_data_o <= mem_rdata;
          end else if (timeout) begin
            mem_req <= 1'b0;
            wb_o    <= '0;
            err_o   <= 1'b1;
          end else begin
            wb_o  <= '0;
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed and randomized checks of stage_mem against a transaction-level model.
module tb_stage_mem;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] alu_in, data_b_in, jump_address_in, mem_rdata;
  logic [4:0]  regaddr_in;
  logic [1:0]  wbi_in;
  logic        M_in, is_jump_in, branch_eq_in, branch_inc_in, zero_in, mem_ack;
  logic        pc_src, flush, stall, mem_req, mem_we, err_o;
  logic [31:0] pc_target, mem_addr, mem_wdata, mem_data_o, alu_o;
  logic [1:0]  wb_o;
  logic [4:0]  regaddr_o;

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] exp_mdata;

  stage_mem #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock           (clock),
    .reset           (reset),
    .alu_in          (alu_in),
    .data_b_in       (data_b_in),
    .regaddr_in      (regaddr_in),
    .wbi_in          (wbi_in),
    .M_in            (M_in),
    .is_jump_in      (is_jump_in),
    .branch_eq_in    (branch_eq_in),
    .branch_inc_in   (branch_inc_in),
    .zero_in         (zero_in),
    .jump_address_in (jump_address_in),
    .pc_src          (pc_src),
    .pc_target       (pc_target),
    .flush           (flush),
    .stall           (stall),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack),
    .wb_o            (wb_o),
    .mem_data_o      (mem_data_o),
    .alu_o           (alu_o),
    .regaddr_o       (regaddr_o),
    .err_o           (err_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bubble();
    alu_in = '0; data_b_in = '0; regaddr_in = '0; wbi_in = '0; M_in = 1'b0;
    is_jump_in = 1'b0; branch_eq_in = 1'b0; branch_inc_in = 1'b0; zero_in = 1'b0;
    jump_address_in = '0; mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  // One random instruction through the stage; the model decides the outcome
  // from the instruction class and the chosen ack delay.
  task automatic rand_instr();
    int          kind, d;
    logic [31:0] a, wd, rd;
    logic [1:0]  wb;
    logic [4:0]  ra;
    logic        m, j, be, bi, z, acc, mis, acked;
    cyc(); bubble();
    kind = $urandom_range(0, 2);
    a = $urandom; wd = $urandom; ra = 5'($urandom);
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    case (kind)
      0:       begin wb = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00; m = 1'b0; end
      1:       begin wb = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01; m = 1'b0; end
      default: begin wb = 2'b00; m = 1'b1; end
    endcase
    j = ($urandom_range(0, 7) == 0); be = 1'($urandom); bi = 1'($urandom); z = 1'($urandom);
    alu_in = a; data_b_in = wd; regaddr_in = ra; wbi_in = wb; M_in = m;
    is_jump_in = j; branch_eq_in = be; branch_inc_in = bi; zero_in = z;
    jump_address_in = $urandom;
    acc = m | wb[0];
    mis = acc && (a[1:0] != 2'b00);
    if (!acc && $urandom_range(0, 1) != 0) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
    end
    settle();
    check("r_pc_src", pc_src, j | (be & z) | (bi & ~z));
    check("r_flush", flush, j | (be & z) | (bi & ~z));
    check("r_pc_target", pc_target, jump_address_in);
    if (!acc || mis) begin
      check("r_stall_idle", stall, 0);
      cyc(); bubble(); settle();
      check("r_wb", wb_o, mis ? 2'b00 : wb);
      check("r_err", err_o, mis);
      check("r_req_none", mem_req, 0);
      check("r_mdata_kept", mem_data_o, exp_mdata);
      if (!acc) begin
        check("r_alu", alu_o, a);
        check("r_reg", regaddr_o, ra);
      end
      return;
    end
    check("r_stall_entry", stall, 1);
    d = $urandom_range(1, TMO + 2);
    acked = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      cyc();
      mem_ack = 1'b0;
      rd = $urandom;
      if (k == d) begin mem_ack = 1'b1; mem_rdata = rd; end
      settle();
      check("r_req", mem_req, 1);
      check("r_addr", mem_addr, a);
      check("r_we", mem_we, m);
      check("r_wdata", mem_wdata, wd);
      check("r_pc_wait", pc_src, 0);
      check("r_wb_wait", wb_o, 0);
      if (k == d) begin
        check("r_stall_ack", stall, 0);
        acked = 1'b1;
        if (wb[0] && !m) exp_mdata = rd;
        break;
      end
      check("r_stall_wait", stall, (k == TMO) ? 0 : 1);
    end
    cyc(); bubble(); settle();
    check("r_req_done", mem_req, 0);
    check("r_mdata", mem_data_o, exp_mdata);
    if (acked) begin
      check("r_wb_done", wb_o, wb);
      check("r_err_none", err_o, 0);
      check("r_alu_done", alu_o, a);
      check("r_reg_done", regaddr_o, ra);
    end else begin
      check("r_wb_tmo", wb_o, 0);
      check("r_err_tmo", err_o, 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    bubble();
    repeat (2) cyc();
    reset = 1'b0;
    settle();
    check("rst_req", mem_req, 0);
    check("rst_wb", wb_o, 0);
    check("rst_err", err_o, 0);
    check("rst_alu", alu_o, 0);
    check("rst_mdata", mem_data_o, 0);
    check("rst_reg", regaddr_o, 0);
    check("rst_stall", stall, 0);

    // ALU op
    cyc(); alu_in = 32'h10; wbi_in = 2'b10; regaddr_in = 5'd5;
    settle(); check("alu_stall", stall, 0);
    cyc(); bubble(); settle();
    check("alu_wb", wb_o, 2'b10);
    check("alu_alu", alu_o, 32'h10);
    check("alu_reg", regaddr_o, 5);
    check("alu_stall2", stall, 0);

    // Load, ack in 3rd WAIT cycle
    cyc(); alu_in = 32'h100; wbi_in = 2'b11; regaddr_in = 5'd7;
    settle(); check("ld_stall0", stall, 1); check("ld_req0", mem_req, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (k == 3) begin mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; end
      settle();
      check("ld_req", mem_req, 1);
      check("ld_addr", mem_addr, 32'h100);
      check("ld_we", mem_we, 0);
      check("ld_stall", stall, (k == 3) ? 0 : 1);
    end
    cyc(); bubble(); settle();
    check("ld_req_off", mem_req, 0);
    check("ld_wb", wb_o, 2'b11);
    check("ld_mdata", mem_data_o, 32'hDEADBEEF);
    check("ld_reg", regaddr_o, 7);

    // Store, ack in 1st WAIT cycle
    cyc(); alu_in = 32'h204; data_b_in = 32'h12345678; M_in = 1'b1;
    settle(); check("st_stall0", stall, 1);
    cyc(); mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; settle();
    check("st_we", mem_we, 1);
    check("st_wdata", mem_wdata, 32'h12345678);
    check("st_addr", mem_addr, 32'h204);
    check("st_stall", stall, 0);
    cyc(); bubble(); settle();
    check("st_req_off", mem_req, 0);
    check("st_wb", wb_o, 0);
    check("st_mdata", mem_data_o, 32'hDEADBEEF);

    // Misaligned load
    cyc(); alu_in = 32'h102; wbi_in = 2'b11;
    settle(); check("mis_stall", stall, 0);
    cyc(); bubble(); settle();
    check("mis_req", mem_req, 0);
    check("mis_err", err_o, 1);
    check("mis_wb", wb_o, 0);
    cyc(); settle(); check("mis_err_pulse", err_o, 0);

    // Timeout
    cyc(); alu_in = 32'h300; wbi_in = 2'b11;
    settle(); check("tmo_stall0", stall, 1);
    for (int k = 1; k <= TMO; k++) begin
      cyc(); settle();
      check("tmo_req", mem_req, 1);
      check("tmo_stall", stall, (k == TMO) ? 0 : 1);
    end
    cyc(); bubble(); settle();
    check("tmo_req_off", mem_req, 0);
    check("tmo_err", err_o, 1);
    check("tmo_wb", wb_o, 0);
    alu_in = 32'h55; wbi_in = 2'b10; regaddr_in = 5'd9;
    settle(); check("tmo_idle_stall", stall, 0);
    cyc(); bubble(); settle();
    check("tmo_after_wb", wb_o, 2'b10);
    check("tmo_after_alu", alu_o, 32'h55);
    check("tmo_after_err", err_o, 0);

    // Branch
    cyc(); branch_inc_in = 1'b1; zero_in = 1'b0; jump_address_in = 32'h40;
    settle();
    check("br_pc_src", pc_src, 1);
    check("br_flush", flush, 1);
    check("br_target", pc_target, 32'h40);
    zero_in = 1'b1;
    settle(); check("br_not_taken", pc_src, 0);

    // Reset while in WAIT
    cyc(); bubble(); alu_in = 32'h400; wbi_in = 2'b11;
    cyc(); is_jump_in = 1'b1; settle();
    check("rw_req", mem_req, 1);
    check("rw_pc_forced", pc_src, 0);
    reset = 1'b1;
    cyc(); bubble(); reset = 1'b0; settle();
    check("rw_req_off", mem_req, 0);
    check("rw_stall", stall, 0);
    check("rw_mdata", mem_data_o, 0);
    check("rw_wb", wb_o, 0);
    exp_mdata = '0;

    for (int n = 0; n < 300; n++) rand_instr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
